// File: rtl/cg_wb_pkg.sv
// cg_wb_pkg: shared target-vector encodings, controller states and chunk-count helper
package cg_wb_pkg;
    localparam logic [1:0] SEL_P       = 2'd0;
    localparam logic [1:0] SEL_R       = 2'd1;
    localparam logic [1:0] SEL_X       = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int calc_chunks(input int clusters, input int eqs, input int units);
        return (clusters * eqs + units - 1) / units;
    endfunction
endpackage

// File: rtl/cg_result_writeback_if.sv
// cg_result_writeback_if: result-chunk input stream plus P/R/X memory write port
interface cg_result_writeback_if #(
    parameter int DW = 512,
    parameter int AW = 20
);
    logic          in_valid;
    logic [1:0]    in_sel;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_ready;
    logic          mem_we_P;
    logic          mem_we_R;
    logic          mem_we_X;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;

    modport master (
        output in_valid, in_sel, in_data, mem_ready,
        input  in_ready, mem_we_P, mem_we_R, mem_we_X, mem_write_address, mem_write_data
    );
    modport slave (
        input  in_valid, in_sel, in_data, mem_ready,
        output in_ready, mem_we_P, mem_we_R, mem_we_X, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with flush; head word is presented combinationally on rdata
module wb_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = cnt_q == (PW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop)
                rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cg_result_writeback.sv
// cg_result_writeback: buffers ALU result chunks and writes them sequentially into the P/R/X memories
module cg_result_writeback
    import cg_wb_pkg::*;
#(
    parameter int number_of_clusters              = 40,
    parameter int number_of_equations_per_cluster = 19,
    parameter int element_width                   = 64,
    parameter int no_of_units                     = 8,
    parameter int memories_address_width          = 20,
    parameter int fifo_depth                      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iteration_start,
    cg_result_writeback_if.slave  bus,
    output logic                  vector_done_P,
    output logic                  vector_done_R,
    output logic                  vector_done_X,
    output logic                  iteration_done,
    output logic                  err_illegal_sel,
    output logic                  err_overrun
);
    localparam int DW = no_of_units * element_width;
    localparam int AW = memories_address_width;
    localparam logic [AW-1:0] LAST =
        AW'(calc_chunks(number_of_clusters, number_of_equations_per_cluster, no_of_units) - 1);

    state_t              state_q, state_d;
    logic [2:0][AW-1:0]  cnt_q, cnt_d;
    logic [2:0]          done_q, done_d, vdone_q, vdone_d, we;
    logic                slot_v_q, slot_v_d;
    logic [1:0]          slot_sel_q, slot_sel_d, head_sel;
    logic [DW-1:0]       slot_data_q, slot_data_d;
    logic                ill_q, ill_d, ovr_q, ovr_d;
    logic                accept, push, pop, retire, last, full, empty;
    logic [DW+1:0]       head;

    assign bus.in_ready = (state_q == RUN) & ~full & ~iteration_start;
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = accept & (bus.in_sel != SEL_ILLEGAL);
    assign retire       = slot_v_q & bus.mem_ready & ~iteration_start;
    assign pop          = ~empty & (~slot_v_q | retire) & ~iteration_start;
    assign head_sel     = head[DW+1:DW];
    assign last         = cnt_q[slot_sel_q] == LAST;

    wb_fifo #(.WIDTH(DW + 2), .DEPTH(fifo_depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (iteration_start),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_sel, bus.in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        vdone_d     = '0;
        slot_v_d    = slot_v_q;
        slot_sel_d  = slot_sel_q;
        slot_data_d = slot_data_q;
        ill_d       = ill_q | (accept & (bus.in_sel == SEL_ILLEGAL));
        ovr_d       = ovr_q;
        if (retire) begin
            cnt_d[slot_sel_q]   = last ? '0 : cnt_q[slot_sel_q] + 1'b1;
            done_d[slot_sel_q]  = done_q[slot_sel_q] | last;
            vdone_d[slot_sel_q] = last;
            slot_v_d            = 1'b0;
        end
        // done_d, not done_q: a chunk loaded alongside its vector's final write is already an overrun
        if (pop) begin
            slot_v_d    = ~done_d[head_sel];
            slot_sel_d  = head_sel;
            slot_data_d = head[DW-1:0];
            ovr_d       = ovr_q | done_d[head_sel];
        end
        if (state_q == RUN && &done_d)
            state_d = DONE;
        else if (state_q == DONE)
            state_d = IDLE;
        if (iteration_start) begin
            state_d  = RUN;
            cnt_d    = '0;
            done_d   = '0;
            vdone_d  = '0;
            slot_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= '0;
            vdone_q     <= '0;
            slot_v_q    <= 1'b0;
            slot_sel_q  <= SEL_P;
            slot_data_q <= '0;
            ill_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            vdone_q     <= vdone_d;
            slot_v_q    <= slot_v_d;
            slot_sel_q  <= slot_sel_d;
            slot_data_q <= slot_data_d;
            ill_q       <= ill_d;
            ovr_q       <= ovr_d;
        end
    end

    assign we                    = {3{slot_v_q & ~iteration_start}} & (3'b001 << slot_sel_q);
    assign bus.mem_we_P          = we[0];
    assign bus.mem_we_R          = we[1];
    assign bus.mem_we_X          = we[2];
    assign bus.mem_write_address = slot_v_q ? cnt_q[slot_sel_q] : '0;
    assign bus.mem_write_data    = slot_data_q;
    assign vector_done_P         = vdone_q[0];
    assign vector_done_R         = vdone_q[1];
    assign vector_done_X         = vdone_q[2];
    assign iteration_done        = state_q == DONE;
    assign err_illegal_sel       = ill_q;
    assign err_overrun           = ovr_q;
endmodule

// File: tb/tb_cg_result_writeback.sv
// tb_cg_result_writeback: randomized stimulus, per-vector expectation queues and a decoupled write monitor
module tb_cg_result_writeback;
    import cg_wb_pkg::*;

    localparam int DW     = 512;
    localparam int AW     = 20;
    localparam int CHUNKS = calc_chunks(40, 19, 8);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iteration_start = 1'b0;
    logic vd_p, vd_r, vd_x, it_done, err_ill, err_ovr;

    cg_result_writeback_if #(.DW(DW), .AW(AW)) bus();

    cg_result_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .iteration_start (iteration_start),
        .bus             (bus.slave),
        .vector_done_P   (vd_p),
        .vector_done_R   (vd_r),
        .vector_done_X   (vd_x),
        .iteration_done  (it_done),
        .err_illegal_sel (err_ill),
        .err_overrun     (err_ovr)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[3][$];
    int   m_cnt[3];
    int   mode = 1;
    logic [2:0] pend_vd = '0;
    logic [2:0] fin = '0;
    logic pend_it = 1'b0;
    logic [2:0] mon_we;
    int   mon_v;
    exp_t mon_e;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data(input int idx);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        d[15:0] = 16'(idx);
        return d;
    endfunction

    // Reference: each vector takes its first CHUNKS accepted chunks in order at addresses 0..CHUNKS-1
    task automatic model_accept(input logic [1:0] sel, input logic [DW-1:0] d);
        exp_t e;
        if (sel == SEL_ILLEGAL || m_cnt[sel] >= CHUNKS) return;
        e.addr = AW'(m_cnt[sel]);
        e.data = d;
        e.last = (m_cnt[sel] == CHUNKS - 1);
        q[sel].push_back(e);
        m_cnt[sel]++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic try_cycle(input logic [1:0] sel, input logic [DW-1:0] d, output logic acc);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        @(negedge clk);
        acc = bus.in_ready;
        if (acc) model_accept(sel, d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] sel, input logic [DW-1:0] d);
        logic acc = 1'b0;
        for (int t = 0; t < 400 && !acc; t++) try_cycle(sel, d, acc);
        check("send_accept", acc, 1);
    endtask

    task automatic start();
        iteration_start = 1'b1;
        for (int v = 0; v < 3; v++) m_cnt[v] = 0;
        cycles(1);
        iteration_start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q[0].size() + q[1].size() + q[2].size() != 0 && t < 3000) begin
            cycles(1);
            t++;
        end
        check("drain_left", q[0].size() + q[1].size() + q[2].size(), 0);
        cycles(2);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        bus.mem_ready = (mode == 2) ? ($urandom_range(3) != 0) : (mode == 1);
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            mon_we = {bus.mem_we_X, bus.mem_we_R, bus.mem_we_P};
            check("we_onehot", $countones(mon_we) <= 1, 1);
            check("vector_done", {vd_x, vd_r, vd_p}, pend_vd);
            check("iteration_done", it_done, pend_it);
            pend_vd = '0;
            pend_it = 1'b0;
            if (iteration_start) begin
                check("we_on_start", mon_we, 0);
                for (int v = 0; v < 3; v++) q[v].delete();
                fin = '0;
            end else if (mon_we != 0 && bus.mem_ready) begin
                mon_v = mon_we[0] ? 0 : mon_we[1] ? 1 : 2;
                if (q[mon_v].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: vector %0d address %0h, required no write",
                             mon_v, bus.mem_write_address);
                end else begin
                    mon_e = q[mon_v].pop_front();
                    check("write_address", bus.mem_write_address, mon_e.addr);
                    check("write_data", bus.mem_write_data, mon_e.data);
                    if (mon_e.last) begin
                        pend_vd[mon_v] = 1'b1;
                        fin[mon_v]     = 1'b1;
                        pend_it        = &fin;
                    end
                end
            end
        end
    end

    initial begin
        logic acc;
        int   acc_cnt, idx;
        logic [2:0] snap_we;
        logic [AW-1:0] snap_addr;
        logic [DW-1:0] snap_data;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.mem_ready = 1'b1;
        for (int v = 0; v < 3; v++) m_cnt[v] = 0;
        cycles(3);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_we", {bus.mem_we_X, bus.mem_we_R, bus.mem_we_P}, 0);
        check("rst_addr", bus.mem_write_address, 0);
        check("rst_data", bus.mem_write_data, 0);
        check("rst_flags", {vd_x, vd_r, vd_p, it_done, err_ill, err_ovr}, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            try_cycle(SEL_P, rnd_data(i), acc);
            check("idle_in_ready", acc, 0);
        end

        // single full P vector, memory always ready
        start();
        for (int i = 0; i < CHUNKS; i++) send(SEL_P, rnd_data(i));
        drain();
        check("p_only_errs", {err_ill, err_ovr}, 0);

        // all three vectors round-robin under random backpressure
        mode = 2;
        start();
        for (int i = 0; i < CHUNKS; i++)
            for (int v = 0; v < 3; v++) send(2'(v), rnd_data(i));
        drain();
        try_cycle(SEL_P, rnd_data(0), acc);
        check("after_done_idle", acc, 0);

        // memory stalled with continuous input: FIFO plus holding slot fill up
        mode = 0;
        start();
        cycles(1);
        acc_cnt = 0;
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            try_cycle(SEL_P, rnd_data(idx), acc);
            if (acc) begin
                acc_cnt++;
                idx++;
            end
            if (i == 3) begin
                snap_we   = {bus.mem_we_X, bus.mem_we_R, bus.mem_we_P};
                snap_addr = bus.mem_write_address;
                snap_data = bus.mem_write_data;
            end else if (i > 3) begin
                check("stall_we", {bus.mem_we_X, bus.mem_we_R, bus.mem_we_P}, snap_we);
                check("stall_addr", bus.mem_write_address, snap_addr);
                check("stall_data", bus.mem_write_data, snap_data);
            end
        end
        check("stall_accepts", acc_cnt, 5);
        check("stall_we_p", snap_we, 3'b001);
        mode = 1;
        for (; idx < 20; idx++) send(SEL_P, rnd_data(idx));
        send(SEL_ILLEGAL, rnd_data(999));
        cycles(2);
        check("err_illegal", err_ill, 1);
        for (; idx < CHUNKS; idx++) send(SEL_P, rnd_data(idx));
        drain();
        check("no_overrun_yet", err_ovr, 0);
        send(SEL_P, rnd_data(CHUNKS));
        cycles(4);
        check("err_overrun", err_ovr, 1);

        // restart mid-vector with entries still buffered
        start();
        for (int i = 0; i < 40; i++) send(SEL_R, rnd_data(i));
        mode = 0;
        cycles(2);
        for (int i = 40; i < 44; i++) send(SEL_R, rnd_data(i));
        start();
        mode = 1;
        check("sticky_illegal", err_ill, 1);
        send(SEL_R, rnd_data(7));
        drain();

        cycles(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cg_result_writeback.md
Name: cg_result_writeback

Overview:
- Receiving end of the complex ALU's result-vector output interface, i.e. its memoryP_input, memoryR_input and memoryX_input streams.
- Accepts no_of_units-wide result chunks tagged with a target vector (P, R or X) and buffers them in a small FIFO.
- Generates per-vector sequential write addresses and write enables toward the P/R/X memories, under memory backpressure.
- Signals vector completion and iteration completion back to the top-level controller.

Parameters:
number_of_clusters, 40, clusters per vector
number_of_equations_per_cluster, 19, equations per cluster; N = clusters*equations = 760 elements
element_width, 64, bits per complex element
no_of_units, 8, elements per chunk; CHUNKS = ceil(N/no_of_units) = 95
memories_address_width, 20, write-address width
fifo_depth, 4, input FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  reset
iteration_start  in  1  one-cycle pulse: clear counters/flags, flush FIFO, enter RUN
in_valid  in  1  result chunk present
in_sel  in  2  target: 0=P, 1=R, 2=X, 3=illegal
in_data  in  no_of_units*element_width  result chunk
in_ready  out  1  chunk accepted on edge where in_valid&in_ready
mem_ready  in  1  memory accepts the pending write this cycle
mem_we_P / mem_we_R / mem_we_X  out  1 each  write strobes (at most one high)
mem_write_address  out  memories_address_width  chunk index within target vector
mem_write_data  out  no_of_units*element_width  chunk data
vector_done_P / vector_done_R / vector_done_X  out  1 each  one-cycle pulse on final chunk of that vector written
iteration_done  out  1  one-cycle pulse, all three vectors complete
err_illegal_sel  out  1  sticky; illegal in_sel accepted and dropped
err_overrun  out  1  sticky; chunk for already-complete vector discarded

Behaviour:
- Interface: single clock clk; reset is synchronous, active-high. Reset: state IDLE, FIFO empty, counters 0, done flags 0, all outputs 0 (in_ready=0, data/address 0, error flags 0).
- States IDLE, RUN, DONE.
  - IDLE -> RUN on iteration_start.
  - RUN -> DONE on the edge the third vector completes.
  - DONE -> IDLE after one cycle; iteration_done=1 only while in DONE.
  - iteration_start in any state -> RUN with counters, done flags and FIFO cleared. It wins over any same-cycle push or write: in_ready is 0 that cycle and mem_we is not issued.
- in_ready = (state==RUN) & !fifo_full & !iteration_start. A push while full never occurs; a simultaneous pop does not open a slot in the same cycle.
- in_sel=3: accepted (handshake completes), not stored, err_illegal_sel set.
- Output stage is a registered holding slot.
  - Loads FIFO head when the slot is empty, or when it is being retired this cycle (mem_we_x & mem_ready).
  - Accepted chunk at edge k drives mem_we_x from after edge k+1 at the earliest.
  - Strobe, address and data hold stable until a cycle with mem_ready=1; retirement happens on that edge.
- Address = per-vector counter cnt[sel], 0..CHUNKS-1.
  - On retirement with cnt==CHUNKS-1: counter wraps to 0, done[sel] set, vector_done_sel pulses in the following cycle.
  - Otherwise counter increments.
- When loading the slot, if done[sel] is already set, the entry is discarded (no strobe) and err_overrun is set.
- Per-vector order is preserved. Interleaving across vectors is arbitrary.
- Error flags clear only on reset.

Decomposition:
- Package cg_wb_pkg holds:
  - sel encodings SEL_P/SEL_R/SEL_X/SEL_ILLEGAL;
  - the state enum;
  - a function computing CHUNKS from the parameters.
- Sub-module wb_fifo: synchronous FIFO with push/pop/full/empty/flush, width 2+no_of_units*element_width, depth fifo_depth.

Test Plan:
- Reset -> all outputs 0, state IDLE; in_valid=1 in IDLE -> in_ready stays 0, no strobes.
- iteration_start, then 95 P chunks with data=index and mem_ready=1 -> mem_we_P with addresses 0..94 in order, each data matches its index; single vector_done_P after address 94; no iteration_done.
- 95 chunks each of P/R/X interleaved round-robin -> each stream addressed 0..94; exactly one iteration_done pulse one cycle after last retirement; next state IDLE.
- mem_ready=0 for 10 cycles with continuous input -> in_ready drops after fifo_depth+1=5 acceptances; outputs stable; on release, writes resume in order with no loss or duplication.
- in_sel=3 chunk mid-stream -> no strobe, err_illegal_sel=1, P address sequence unaffected; 96th P chunk -> discarded, err_overrun=1.
- iteration_start after 40 R chunks, with FIFO holding 3 entries -> FIFO flushed, cnt_R=0; next R chunk written at address 0.
